// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a first-word-fall-through
// receive FIFO, with sticky error flags and optional line-break detection.
//
// Optional feature macro: UART_RX_FIFO_BREAK_DETECT_EN
//   defined   -> an all-zero frame (data, parity, stop) is reported as a line
//                break: the receiver waits for rx to return high and then
//                pulses break_det for one cycle; no push, no framing error.
//   undefined -> break_det is tied low; a break is an ordinary framing error.
//
// Ports:
//   clk          system clock (only clock)
//   resetn       asynchronous active-low reset
//   rx           serial line, idle high, asynchronous to clk
//   data         head-of-FIFO frame, 0 while data_valid is low
//   data_valid   FIFO not empty
//   data_ready   consumer accepts data this cycle (pop when valid && ready)
//   count        FIFO occupancy
//   parity_err   sticky: a frame failed the parity check
//   framing_err  sticky: a stop bit was sampled low
//   overrun      sticky: a good frame arrived while the FIFO was full
//   err_clear    one-cycle pulse clearing all sticky flags
//   break_det    one-cycle pulse when a line break ends
module uart_rx_fifo #(
  parameter int CLOCK_HZ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                rx,
  output logic [DATA_BITS-1:0]                data,
  output logic                                data_valid,
  input  logic                                data_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
  output logic                                parity_err,
  output logic                                framing_err,
  output logic                                overrun,
  input  logic                                err_clear,
  output logic                                break_det
);

  localparam int DIV_RAW = CLOCK_HZ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = $clog2(FIFO_DEPTH + 1);

  localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_DEC  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser. Reset low so a line that is really idle has to be
  // observed high before the receiver arms.
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_sync;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Free-running oversample tick
  // ---------------------------------------------------------------------------
  logic tick;

  generate
    if (DIV == 1) begin : g_tick_every
      assign tick = 1'b1;
    end else begin : g_tick_div
      localparam int DW = $clog2(DIV);
      localparam logic [DW-1:0] D_LAST = DW'(DIV - 1);
      logic [DW-1:0] div_cnt;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                div_cnt <= '0;
        else if (div_cnt == D_LAST) div_cnt <= '0;
        else                        div_cnt <= div_cnt + 1'b1;
      end

      assign tick = (div_cnt == D_LAST);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------------------
  state_t               state;
  logic [TW-1:0]        tick_idx;
  logic [1:0]           samp;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 armed;
  logic                 brk_wait;

  logic vote, stop_dec, par_bad, is_break, frame_good;
  logic pop, full, push;

  always_comb begin
    // Third sample is the live value at the decision tick.
    vote     = (samp[0] & samp[1]) | (samp[0] & rx_sync) | (samp[1] & rx_sync);
    stop_dec = (state == STOP) && tick && (tick_idx == T_DEC) && !brk_wait;
    par_bad  = (PARITY != 0) &&
               (par_bit != ((PARITY == 1) ? ~^shreg : ^shreg));
`ifdef UART_RX_FIFO_BREAK_DETECT_EN
    is_break = (shreg == '0) && ((PARITY == 0) || !par_bit) && !vote;
`else
    is_break = 1'b0;
`endif
    frame_good = stop_dec && vote && !par_bad;
    pop        = data_valid && data_ready;
    full       = (count == C_FULL);
    // A pop in the same cycle frees the slot a full FIFO needs.
    push       = frame_good && (!full || pop);
  end

`ifndef UART_RX_FIFO_BREAK_DETECT_EN
  assign brk_wait  = 1'b0;
  assign break_det = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      tick_idx <= '0;
      samp     <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      armed    <= 1'b0;
`ifdef UART_RX_FIFO_BREAK_DETECT_EN
      brk_wait  <= 1'b0;
      break_det <= 1'b0;
`endif
    end else begin
`ifdef UART_RX_FIFO_BREAK_DETECT_EN
      break_det <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rx_sync) begin
            armed <= 1'b1;
          end else if (tick && armed) begin
            // The detecting tick counts as tick 0 of the start bit.
            state    <= START;
            tick_idx <= TW'(1);
            armed    <= 1'b0;
          end
        end
        default: begin
`ifdef UART_RX_FIFO_BREAK_DETECT_EN
          if (brk_wait) begin
            if (rx_sync) begin
              brk_wait  <= 1'b0;
              break_det <= 1'b1;
              state     <= IDLE;
            end
          end else
`endif
          if (tick) begin
            tick_idx <= (tick_idx == T_END) ? '0 : tick_idx + 1'b1;
            if (tick_idx == T_S0) samp[0] <= rx_sync;
            if (tick_idx == T_S1) samp[1] <= rx_sync;
            if (tick_idx == T_DEC) begin
              case (state)
                START: if (vote) state <= IDLE;
                DATA:  shreg   <= {vote, shreg[DATA_BITS-1:1]};
                PAR:   par_bit <= vote;
                STOP: begin
`ifdef UART_RX_FIFO_BREAK_DETECT_EN
                  if (is_break) brk_wait <= 1'b1;
                  else          state    <= IDLE;
`else
                  state <= IDLE;
`endif
                end
                default: ;
              endcase
            end
            if (tick_idx == T_END) begin
              case (state)
                START: begin
                  state   <= DATA;
                  bit_cnt <= '0;
                end
                DATA: begin
                  if (bit_cnt == B_LAST) state   <= (PARITY != 0) ? PAR : STOP;
                  else                   bit_cnt <= bit_cnt + 1'b1;
                end
                PAR:     state <= STOP;
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: a new event wins over err_clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (stop_dec && vote && par_bad)       parity_err <= 1'b1;
      else if (err_clear)                    parity_err <= 1'b0;

      if (stop_dec && !vote && !is_break)    framing_err <= 1'b1;
      else if (err_clear)                    framing_err <= 1'b0;

      if (frame_good && full && !pop)        overrun <= 1'b1;
      else if (err_clear)                    overrun <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    data_valid = (count != '0);
    data       = data_valid ? mem[rd_ptr] : '0;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with an integrated receive FIFO and error reporting. It takes the asynchronous serial input pin, oversamples it with majority voting, and supports configurable data width and parity. Completed frames are buffered in a first-word-fall-through FIFO with a valid/ready read port. It is the next-generation receive front end between the board UART pin and downstream consumers such as display or command logic.

## Interface
- `CLOCK_HZ`, 50000000: system clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in bits per second.
- `OVERSAMPLE`, 16: sample ticks per bit; even, ≥ 8.
- `DATA_BITS`, 8: data bits per frame; 5–9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `FIFO_DEPTH`, 8: entries; power of two, ≥ 2.
- `clk`  in  1: system clock; the only clock.
- `resetn`  in  1: reset, asynchronous, active-low.
- `rx`  in  1: serial line, idle high, asynchronous to `clk`.
- `data`  out  DATA_BITS: head-of-FIFO frame; reads 0 whenever `data_valid` = 0.
- `data_valid`  out  1: FIFO not empty.
- `data_ready`  in  1: consumer accepts `data` this cycle.
- `count`  out  $clog2(FIFO_DEPTH+1): current occupancy.
- `parity_err`  out  1: sticky; a frame failed the parity check.
- `framing_err`  out  1: sticky; a stop bit was sampled low.
- `overrun`  out  1: sticky; a good frame arrived while the FIFO was full.
- `err_clear`  in  1: one-cycle pulse that clears all sticky flags.
- `break_det`  out  1: one-cycle pulse on line break; constant 0 when the feature is compiled out.

## Operation
- `rx` passes through a 2-flop synchroniser. All logic below uses the synchronised value.
- Tick generator:
  - Divisor = max(1, CLOCK_HZ / (BAUD_RATE × OVERSAMPLE)), integer floor.
  - One tick pulse every divisor cycles, free-running.
- Bit sampling: each bit is the majority of three samples taken at ticks OVERSAMPLE/2−1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE → START: on synchronised `rx` = 0, but only after `rx` = 1 has been seen since the last frame or since reset.
  - START: the voted start bit is evaluated. If it is 1, the pulse was a glitch: return to IDLE with no flags set. If it is 0, go to DATA.
  - DATA: shift in DATA_BITS bits, LSB first. Then go to PAR if PARITY ≠ 0, otherwise to STOP.
  - PAR: sample the parity bit and compare it against the computed parity.
  - STOP: evaluate the stop bit at its centre tick, then go to IDLE in the same cycle. No wait for the end of the stop bit, so back-to-back frames are received.
- Frame disposition, evaluated at the STOP centre:
  - Stop bit 0: set `framing_err` and discard the frame. Break handling overrides this when the feature is compiled in.
  - Parity mismatch (stop bit good): set `parity_err` and discard the frame.
  - Otherwise, FIFO not full, or full with a pop in the same cycle: push the frame.
  - Otherwise (full, no pop): set `overrun` and drop the new frame. FIFO contents are unchanged.
- FIFO:
  - A pop happens when `data_valid` && `data_ready`.
  - A simultaneous push and pop leaves `count` unchanged, including when full or when holding one entry.
  - Pointers wrap modulo FIFO_DEPTH.
- `err_clear` coinciding with a new error event: the error wins and the flag stays 1.

## Timing
- Reset values: `data_valid` 0, `data` 0, `count` 0, all error flags 0, `break_det` 0, FSM in IDLE, FIFO empty.
- Reset asserted mid-frame aborts the frame immediately. After release the FSM requires `rx` high before accepting a start bit.
- Input latency: 2 cycles through the synchroniser plus up to one tick to the start edge.
- Push latency: `data_valid` and the `count` increment appear on the cycle after the STOP centre-tick cycle.
- Error flags rise on the cycle after the STOP or PAR decision.
- Pop: `data`, `count` and `data_valid` update on the clock edge that completes the handshake. No bubble between consecutive entries.

## Configuration
- Macro: `UART_RX_FIFO_BREAK_DETECT_EN`.
- When defined:
  - Break condition: all data bits, the parity bit (if present) and the stop bit are sampled 0.
  - On break: no push and no `framing_err`. The FSM waits in STOP until `rx` returns high, then pulses `break_det` for one cycle and goes to IDLE.
- When undefined: `break_det` is tied to 0, and a break is handled as an ordinary framing error (frame discarded).

## Test plan
Bench parameters: CLOCK_HZ = 1600000, BAUD_RATE = 100000, OVERSAMPLE = 16 (divisor 1, so 16 cycles per bit).
- 8N1 frame 0xA5, `data_ready` = 0 → `data_valid` = 1, `data` = 0xA5, `count` = 1, no flags; pulsing `data_ready` → `count` = 0.
- PARITY = 2, byte 0x3C sent with parity bit 1 → `parity_err` = 1, `count` = 0; `err_clear` pulse → `parity_err` = 0.
- 0x55 sent with stop bit 0 → `framing_err` = 1, nothing pushed; next good frame 0x12 is received normally.
- FIFO_DEPTH = 4, frames 0x01–0x05 sent with `data_ready` = 0 → `count` = 4, `overrun` = 1; draining yields 0x01, 0x02, 0x03, 0x04 in order.
- `rx` low for 4 cycles then high → no state change, `count` = 0, no flags.
- `rx` low for 12 bit times:
  - With the macro defined → one `break_det` pulse after `rx` rises, `framing_err` = 0, `count` = 0.
  - Without the macro → `framing_err` = 1, `count` = 0.
